// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/writeback/stall bundle between the decode stage and the hazard scoreboard
interface hazard_scoreboard_if #(
    parameter int INF_W = 3
);
    logic [4:0]       ra;
    logic [4:0]       rb;
    logic             rs1_used;
    logic             rs2_used;
    logic [4:0]       rd;
    logic             regw;
    logic             serialize;
    logic             issue_fire;
    logic             wb_valid;
    logic             wb_regw;
    logic [4:0]       wb_waddr;
    logic             stall;
    logic             busy;
    logic [INF_W-1:0] inflight;
    logic             err;

    modport master (
        output ra, rb, rs1_used, rs2_used, rd, regw, serialize, issue_fire,
        output wb_valid, wb_regw, wb_waddr,
        input  stall, busy, inflight, err
    );

    modport slave (
        input  ra, rb, rs1_used, rs2_used, rd, regw, serialize, issue_fire,
        input  wb_valid, wb_regw, wb_waddr,
        output stall, busy, inflight, err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters and in-flight count that stall decode on hazards
module hazard_scoreboard #(
    parameter int NREG         = 16,
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int INF_W        = 3
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [INF_W-1:0] inflight_q;
    logic [INF_W-1:0] inflight_d;
    logic             err_q;
    logic             err_d;
    logic             stall;
    logic             issue;
    logic             wb_hit_zero;

    // Stall from registered state only, then next-state of every counter and the sticky error
    always_comb begin
        stall = (inflight_q == INF_W'(MAX_INFLIGHT)) || (sb.serialize && inflight_q != '0);
        wb_hit_zero = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            stall = stall
                  | (sb.rs1_used && sb.ra == 5'(r) && cnt_q[r] != '0)
                  | (sb.rs2_used && sb.rb == 5'(r) && cnt_q[r] != '0)
                  | (sb.regw && sb.rd == 5'(r) && cnt_q[r] == CMAX);
        end
        issue = sb.issue_fire && !stall;
        for (int r = 1; r < NREG; r++) begin
            wb_hit_zero = wb_hit_zero | (sb.wb_valid && sb.wb_regw && sb.wb_waddr == 5'(r) && cnt_q[r] == '0);
            cnt_d[r] = cnt_q[r]
                     + CNT_W'(issue && sb.regw && sb.rd == 5'(r))
                     - CNT_W'(sb.wb_valid && sb.wb_regw && sb.wb_waddr == 5'(r) && cnt_q[r] != '0);
        end
        inflight_d = inflight_q + INF_W'(issue) - INF_W'(sb.wb_valid && inflight_q != '0);
        err_d = err_q | (sb.issue_fire && stall) | (sb.wb_valid && inflight_q == '0) | wb_hit_zero;
    end

    // Tracking state; reset discards everything outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '{default: '0};
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign sb.stall    = stall;
    assign sb.busy     = inflight_q != '0;
    assign sb.inflight = inflight_q;
    assign sb.err      = err_q;
endmodule
